// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the writeback path.
//   - XLEN            : default datapath width, matches register_file
//   - load_funct3_e   : load funct3 encodings understood by load_formatter
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_funct3_e;

endpackage : riscv_pkg

// File: rtl/load_formatter.sv
// load_formatter
//   Combinational shift and sign/zero extension of an aligned memory word
//   into the value written back for a load.
//   Ports:
//     i_funct3  in  3     load type (LB, LH, LW, LBU, LHU; others act as LW)
//     i_offset  in  2     address[1:0], byte lane of the access
//     i_data    in  XLEN  raw aligned memory word
//     o_data    out XLEN  formatted load result
module load_formatter #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);
  import riscv_pkg::*;

  // Only the low half-word of the shifted word is ever used; full words
  // bypass the shifter entirely.
  logic [15:0] shifted_lo;
  assign shifted_lo = 16'(i_data >> {i_offset, 3'b000});

  always_comb begin
    o_data = i_data;
    case (load_funct3_e'(i_funct3))
      LD_B:    o_data = {{(XLEN-8){shifted_lo[7]}}, shifted_lo[7:0]};
      LD_BU:   o_data = {{(XLEN-8){1'b0}}, shifted_lo[7:0]};
      LD_H:    o_data = {{(XLEN-16){shifted_lo[15]}}, shifted_lo};
      LD_HU:   o_data = {{(XLEN-16){1'b0}}, shifted_lo};
      default: o_data = i_data;
    endcase
  end

endmodule : load_formatter

// File: rtl/writeback_unit.sv
// writeback_unit
//   Arbitrates ALU and LSU results onto the single register_file write
//   port, formats load data, and keeps a per-register pending scoreboard
//   so decode can stall on RAW hazards.
//   Ports:
//     i_clk, i_reset_n                 clock (rising edge), async active-low reset
//     i_alu_valid/o_alu_ready          ALU result handshake, i_alu_rd/i_alu_data
//     i_lsu_valid/o_lsu_ready          load result handshake, i_lsu_rd, i_lsu_funct3,
//                                      i_lsu_offset, i_lsu_data
//     i_issue_valid, i_issue_rd        decode marks a destination as pending
//     i_rs1, i_rs2 -> o_rs1_busy,
//                     o_rs2_busy       source has a write not yet visible
//     o_wb_valid, o_rd, o_rd_data      registered register_file write
//   Optional feature (macro WB_FWD_EN): adds o_rsX_fwd_valid/o_rsX_fwd_data
//   forwarding of the presented write; busy then covers pending bits only.
module writeback_unit #(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [1:0]      i_lsu_offset,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
`ifdef WB_FWD_EN
  output logic            o_rs1_fwd_valid,
  output logic [XLEN-1:0] o_rs1_fwd_data,
  output logic            o_rs2_fwd_valid,
  output logic [XLEN-1:0] o_rs2_fwd_data,
`endif
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_wb_valid
);
  import riscv_pkg::*;

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]   starve_cnt_reg, starve_cnt_next;
  logic [31:0]     pending_reg, pending_next;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] rd_data_reg;
  logic            wb_valid_reg;

  logic            starved;
  logic            alu_win;
  logic            alu_xfer, lsu_xfer, xfer;
  logic [4:0]      xfer_rd;
  logic [XLEN-1:0] xfer_data;
  logic [XLEN-1:0] load_data;

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .i_funct3 (i_lsu_funct3),
    .i_offset (i_lsu_offset),
    .i_data   (i_lsu_data),
    .o_data   (load_data)
  );

  // LSU wins by default; the ALU takes the port when it is alone or has
  // lost STARVE_LIMIT times in a row.
  assign starved  = (starve_cnt_reg == CW'(STARVE_LIMIT));
  assign alu_win  = i_alu_valid && (!i_lsu_valid || starved);

  // Readies are forced low while reset is held so nothing is consumed.
  assign o_alu_ready = i_reset_n && alu_win;
  assign o_lsu_ready = i_reset_n && i_lsu_valid && !alu_win;

  assign alu_xfer  = i_alu_valid && o_alu_ready;
  assign lsu_xfer  = i_lsu_valid && o_lsu_ready;
  assign xfer      = alu_xfer || lsu_xfer;
  assign xfer_rd   = alu_xfer ? i_alu_rd   : i_lsu_rd;
  assign xfer_data = alu_xfer ? i_alu_data : load_data;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!i_alu_valid || alu_xfer) begin
      starve_cnt_next = '0;
    end else if (!starved) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // Pending bits: a younger issue to the same register overrides the clear
  // from a retiring older write. x0 is never pending.
  assign pending_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      assign pending_next[gi] = (i_issue_valid && (i_issue_rd == 5'(gi))) ||
                                (pending_reg[gi] && !(xfer && (xfer_rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_cnt_reg <= '0;
      pending_reg    <= '0;
      rd_reg         <= '0;
      rd_data_reg    <= '0;
      wb_valid_reg   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      pending_reg    <= pending_next;
      wb_valid_reg   <= xfer;
      if (xfer) begin
        rd_reg      <= xfer_rd;
        rd_data_reg <= xfer_data;
      end else begin
        // Data is left holding so the write bus does not toggle needlessly.
        rd_reg      <= '0;
      end
    end
  end

  assign o_rd       = rd_reg;
  assign o_rd_data  = rd_data_reg;
  assign o_wb_valid = wb_valid_reg;

  // The presented write lands in register_file at the next edge, so a
  // reader this cycle would still see the stale value.
  logic inflight_rs1, inflight_rs2;
  assign inflight_rs1 = wb_valid_reg && (rd_reg == i_rs1) && (rd_reg != 5'd0);
  assign inflight_rs2 = wb_valid_reg && (rd_reg == i_rs2) && (rd_reg != 5'd0);

`ifdef WB_FWD_EN
  assign o_rs1_fwd_valid = inflight_rs1;
  assign o_rs1_fwd_data  = rd_data_reg;
  assign o_rs2_fwd_valid = inflight_rs2;
  assign o_rs2_fwd_data  = rd_data_reg;
  assign o_rs1_busy      = pending_reg[i_rs1];
  assign o_rs2_busy      = pending_reg[i_rs2];
`else
  assign o_rs1_busy      = pending_reg[i_rs1] || inflight_rs1;
  assign o_rs2_busy      = pending_reg[i_rs2] || inflight_rs2;
`endif

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
//   Randomized and directed stimulus for writeback_unit, checked every
//   cycle against a behavioural model of arbitration, load formatting,
//   write presentation and the pending scoreboard.
module tb_writeback_unit;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_alu_valid;
  logic            o_alu_ready;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [4:0]      i_lsu_rd;
  logic [2:0]      i_lsu_funct3;
  logic [1:0]      i_lsu_offset;
  logic [XLEN-1:0] i_lsu_data;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd;
  logic [4:0]      i_rs1, i_rs2;
  logic            o_rs1_busy, o_rs2_busy;
  logic [4:0]      o_rd;
  logic [XLEN-1:0] o_rd_data;
  logic            o_wb_valid;
`ifdef WB_FWD_EN
  logic            o_rs1_fwd_valid, o_rs2_fwd_valid;
  logic [XLEN-1:0] o_rs1_fwd_data, o_rs2_fwd_data;
`endif

  always #5 i_clk = ~i_clk;

  writeback_unit #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_alu_valid   (i_alu_valid),
    .o_alu_ready   (o_alu_ready),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .i_lsu_valid   (i_lsu_valid),
    .o_lsu_ready   (o_lsu_ready),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_funct3  (i_lsu_funct3),
    .i_lsu_offset  (i_lsu_offset),
    .i_lsu_data    (i_lsu_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
`ifdef WB_FWD_EN
    .o_rs1_fwd_valid (o_rs1_fwd_valid),
    .o_rs1_fwd_data  (o_rs1_fwd_data),
    .o_rs2_fwd_valid (o_rs2_fwd_valid),
    .o_rs2_fwd_data  (o_rs2_fwd_data),
`endif
    .o_rd          (o_rd),
    .o_rd_data     (o_rd_data),
    .o_wb_valid    (o_wb_valid)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pending[32];
  int          m_losses;          // consecutive ALU losses, capped at LIMIT
  bit          m_wb_valid;
  int          m_rd;
  logic [31:0] m_rd_data;
  bit          alu_stalled, lsu_stalled;
  bit          last_alu_rdy;

  function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] w);
    longint unsigned sh;
    longint unsigned b, h;
    sh = longint'(w) / (longint'(1) << (8 * off));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      0:       return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      4:       return 32'(b);
      1:       return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      5:       return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_pending[k]) m_pending[k] = 1'b0;
    m_losses   = 0;
    m_wb_valid = 1'b0;
    m_rd       = 0;
    m_rd_data  = '0;
    alu_stalled = 1'b0;
    lsu_stalled = 1'b0;
  endtask

  function automatic bit model_busy(input int rs);
    bit inflight;
    inflight = m_wb_valid && (m_rd == rs) && (rs != 0);
`ifdef WB_FWD_EN
    return m_pending[rs];
`else
    return m_pending[rs] || inflight;
`endif
  endfunction

  // Called at negedge+1 with the cycle's inputs applied: checks, advances
  // the model across the coming edge, and moves to the next negedge+1.
  task automatic step();
    bit exp_alu, exp_lsu;
    int xrd;
    logic [31:0] xdata;
    #1;
    exp_alu = 1'b0;
    exp_lsu = 1'b0;
    if (i_alu_valid && i_lsu_valid) begin
      if (m_losses >= LIMIT) exp_alu = 1'b1;
      else                   exp_lsu = 1'b1;
    end else begin
      exp_alu = i_alu_valid;
      exp_lsu = i_lsu_valid;
    end
    last_alu_rdy = o_alu_ready;
    check_val("alu_ready", o_alu_ready, exp_alu);
    check_val("lsu_ready", o_lsu_ready, exp_lsu);
    check_val("rs1_busy", o_rs1_busy, model_busy(int'(i_rs1)));
    check_val("rs2_busy", o_rs2_busy, model_busy(int'(i_rs2)));
    check_val("wb_valid", o_wb_valid, m_wb_valid);
    check_val("wb_rd", o_rd, m_rd);
    check_val("wb_data", o_rd_data, m_rd_data);
`ifdef WB_FWD_EN
    check_val("rs1_fwd_valid", o_rs1_fwd_valid, m_wb_valid && m_rd == int'(i_rs1) && m_rd != 0);
    if (o_rs1_fwd_valid) check_val("rs1_fwd_data", o_rs1_fwd_data, m_rd_data);
    check_val("rs2_fwd_valid", o_rs2_fwd_valid, m_wb_valid && m_rd == int'(i_rs2) && m_rd != 0);
`endif
    // advance the model across the edge
    xrd = -1;
    xdata = '0;
    if (exp_alu) begin
      xrd = int'(i_alu_rd); xdata = i_alu_data;
      $display("xfer alu rd=%0d data=%08h", xrd, xdata);
    end else if (exp_lsu) begin
      xrd = int'(i_lsu_rd);
      xdata = model_load(int'(i_lsu_funct3), int'(i_lsu_offset), i_lsu_data);
      $display("xfer lsu rd=%0d f3=%0d off=%0d data=%08h", xrd, i_lsu_funct3, i_lsu_offset, xdata);
    end
    if (xrd >= 0) begin
      m_pending[xrd] = 1'b0;
      m_wb_valid = 1'b1; m_rd = xrd; m_rd_data = xdata;
    end else begin
      m_wb_valid = 1'b0; m_rd = 0;
    end
    if (i_issue_valid && i_issue_rd != 0) m_pending[i_issue_rd] = 1'b1;
    if (!i_alu_valid || exp_alu) m_losses = 0;
    else if (m_losses < LIMIT)   m_losses++;
    alu_stalled = i_alu_valid && !exp_alu;
    lsu_stalled = i_lsu_valid && !exp_lsu;
    @(negedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_alu_valid   = 1'b0;
    i_lsu_valid   = 1'b0;
    i_issue_valid = 1'b0;
  endtask

  task automatic set_lsu(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] d);
    i_lsu_valid = 1'b1; i_lsu_rd = rd; i_lsu_funct3 = f3; i_lsu_offset = off; i_lsu_data = d;
  endtask

  logic [5:0] grants;

  initial begin
    i_reset_n = 1'b0;
    i_alu_rd = '0; i_alu_data = '0; i_lsu_rd = '0; i_lsu_funct3 = '0;
    i_lsu_offset = '0; i_lsu_data = '0; i_issue_rd = '0; i_rs1 = '0; i_rs2 = '0;
    idle();
    model_reset();
    repeat (2) @(negedge i_clk);
    #1;
    check_val("rst_wb_valid", o_wb_valid, 0);
    check_val("rst_rd", o_rd, 0);
    check_val("rst_rd_data", o_rd_data, 0);
    i_alu_valid = 1'b1;
    #1;
    check_val("rst_alu_ready", o_alu_ready, 0);
    i_alu_valid = 1'b0;
    i_reset_n = 1'b1;

    // ALU single transfer
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234;
    step();
    check_val("alu_first_ready", last_alu_rdy, 1);
    idle();
    check_val("alu_wb_valid", o_wb_valid, 1);
    check_val("alu_wb_rd", o_rd, 5);
    check_val("alu_wb_data", o_rd_data, 32'h0000_1234);
    step();

    // load formatting
    set_lsu(5'd3, 3'b000, 2'd2, 32'h00F0_0000); step(); idle();
    check_val("lb_off2", o_rd_data, 32'hFFFF_FFF0); step();
    set_lsu(5'd3, 3'b100, 2'd2, 32'h00F0_0000); step(); idle();
    check_val("lbu_off2", o_rd_data, 32'h0000_00F0); step();
    set_lsu(5'd4, 3'b101, 2'd2, 32'h8001_0000); step(); idle();
    check_val("lhu_off2", o_rd_data, 32'h0000_8001); step();

    // starvation: LSU x4, ALU on the 5th, then LSU again
    i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'hA5A5_0001;
    set_lsu(5'd2, 3'b010, 2'd0, 32'h5A5A_0002);
    for (int i = 0; i < 6; i++) begin
      step();
      grants[i] = last_alu_rdy;
    end
    check_val("starve_pattern", grants, 6'b010000);
    idle(); step(); step();

    // scoreboard on x7
    i_rs1 = 5'd7; i_rs2 = 5'd0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd7; step(); idle();
    check_val("busy7_pending", o_rs1_busy, 1); step();
    set_lsu(5'd7, 3'b010, 2'd0, 32'h7777_7777); step(); idle();
    check_val("busy7_inflight", o_rs1_busy, 1); step();
    check_val("busy7_done", o_rs1_busy, 0);
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    set_lsu(5'd7, 3'b010, 2'd0, 32'h0000_0777); step(); idle(); step();
    check_val("busy7_set_wins", o_rs1_busy, 1);
    i_alu_valid = 1'b1; i_alu_rd = 5'd7; step(); idle(); step();

    // x0 never busy, rd=0 still presented
    i_rs1 = 5'd0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hDEAD_0000;
    step(); idle();
    check_val("x0_busy", o_rs1_busy, 0);
    check_val("x0_wb_valid", o_wb_valid, 1);
    check_val("x0_wb_rd", o_rd, 0);
    step();

    // asynchronous reset while a write is presented
    i_issue_valid = 1'b1; i_issue_rd = 5'd12;
    i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h0909_0909;
    i_rs1 = 5'd12; i_rs2 = 5'd9;
    step();
    i_issue_valid = 1'b0;
    check_val("pre_rst_wb_valid", o_wb_valid, 1);
    i_reset_n = 1'b0;
    #1;
    check_val("mid_rst_wb_valid", o_wb_valid, 0);
    check_val("mid_rst_rd", o_rd, 0);
    check_val("mid_rst_rd_data", o_rd_data, 0);
    check_val("mid_rst_alu_ready", o_alu_ready, 0);
    check_val("mid_rst_rs1_busy", o_rs1_busy, 0);
    check_val("mid_rst_rs2_busy", o_rs2_busy, 0);
    model_reset();
    idle();
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!alu_stalled) begin
        i_alu_valid = ($urandom_range(0, 99) < 60);
        i_alu_rd    = 5'($urandom_range(0, 7));
        i_alu_data  = $urandom;
      end
      if (!lsu_stalled) begin
        i_lsu_valid  = ($urandom_range(0, 99) < 60);
        i_lsu_rd     = 5'($urandom_range(0, 7));
        i_lsu_funct3 = 3'($urandom_range(0, 7));
        i_lsu_offset = 2'($urandom_range(0, 3));
        i_lsu_data   = $urandom;
      end
      i_issue_valid = ($urandom_range(0, 99) < 40);
      i_issue_rd    = 5'($urandom_range(0, 7));
      i_rs1         = 5'($urandom_range(0, 7));
      i_rs2         = 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_writeback_unit
